// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter that shares the register-file write port, with read-port A/B forwarding.
// Latency: 1 cycle from grant to the RF write. Forwarding flags are combinational.
// Backpressure: grants at most one requester per cycle. freeze_i stalls grants. The output stage never stalls.
//
// Ports:
//   clk, rst_n                 clock and asynchronous active-low reset
//   freeze_i                   1 = grant nothing this cycle
//   req_valid_i / req_ready_o  per-requester handshake; ready is one-hot or zero
//   req_addr_i / req_data_i    packed per-requester write address and data
//   rf_we_o, rf_addr_wr_o, rf_data_o, grant_id_o   registered output stage (RF write port)
//   rd_addr_a_i / rd_addr_b_i  read-port addresses checked against the in-flight write
//   fwd_a_o / fwd_b_o          read port must take rf_data_o instead of the RF value
module rf_write_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 3,
    parameter int N_REQ      = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          freeze_i,
    input  logic [N_REQ-1:0]              req_valid_i,
    output logic [N_REQ-1:0]              req_ready_o,
    input  logic [N_REQ*ADDR_WIDTH-1:0]   req_addr_i,
    input  logic [N_REQ*DATA_WIDTH-1:0]   req_data_i,
    output logic                          rf_we_o,
    output logic [ADDR_WIDTH-1:0]         rf_addr_wr_o,
    output logic [DATA_WIDTH-1:0]         rf_data_o,
    output logic [1:0]                    grant_id_o,
    input  logic [ADDR_WIDTH-1:0]         rd_addr_a_i,
    input  logic [ADDR_WIDTH-1:0]         rd_addr_b_i,
    output logic                          fwd_a_o,
    output logic                          fwd_b_o
);

    logic [1:0]            ptr_q, ptr_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [1:0]            gid_q, gid_d;

    logic [N_REQ-1:0]      gnt;
    logic                  found;
    logic [1:0]            win;
    int                    scan_idx;

    // Scan from the pointer, wrapping modulo N_REQ. The first valid requester wins.
    // Grants are also gated by rst_n, so nothing is accepted while reset is held.
    always_comb begin
        gnt      = '0;
        found    = 1'b0;
        win      = 2'd0;
        scan_idx = 0;
        if (!freeze_i && rst_n) begin
            for (int i = 0; i < N_REQ; i++) begin
                scan_idx = int'(ptr_q) + i;
                if (scan_idx >= N_REQ) begin
                    scan_idx = scan_idx - N_REQ;
                end
                if (!found && req_valid_i[scan_idx]) begin
                    found         = 1'b1;
                    gnt[scan_idx] = 1'b1;
                    win           = scan_idx[1:0];
                end
            end
        end
    end

    assign req_ready_o = gnt;

    // Next state. A transfer loads the output stage and moves the pointer past the winner.
    // With no transfer, only the write enable drops and everything else holds.
    always_comb begin
        we_d   = found;
        addr_d = addr_q;
        data_d = data_q;
        gid_d  = gid_q;
        ptr_d  = ptr_q;
        if (found) begin
            addr_d = req_addr_i[win*ADDR_WIDTH +: ADDR_WIDTH];
            data_d = req_data_i[win*DATA_WIDTH +: DATA_WIDTH];
            gid_d  = win;
            ptr_d  = (int'(win) == N_REQ - 1) ? 2'd0 : win + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q  <= 2'd0;
            we_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
            gid_q  <= 2'd0;
        end else begin
            ptr_q  <= ptr_d;
            we_q   <= we_d;
            addr_q <= addr_d;
            data_q <= data_d;
            gid_q  <= gid_d;
        end
    end

    assign rf_we_o      = we_q;
    assign rf_addr_wr_o = addr_q;
    assign rf_data_o    = data_q;
    assign grant_id_o   = gid_q;

    // A read of the register being written this cycle would return the old RF contents.
    assign fwd_a_o = we_q && (addr_q == rd_addr_a_i);
    assign fwd_b_o = we_q && (addr_q == rd_addr_b_i);

endmodule

// File: tb/tb_rf_write_arbiter.sv
module tb_rf_write_arbiter;

    localparam int DW = 32;
    localparam int AW = 3;
    localparam int NR = 3;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           freeze_i;
    logic [NR-1:0]  req_valid_i;
    logic [NR-1:0]  req_ready_o;
    logic [NR*AW-1:0] req_addr_i;
    logic [NR*DW-1:0] req_data_i;
    logic           rf_we_o;
    logic [AW-1:0]  rf_addr_wr_o;
    logic [DW-1:0]  rf_data_o;
    logic [1:0]     grant_id_o;
    logic [AW-1:0]  rd_addr_a_i;
    logic [AW-1:0]  rd_addr_b_i;
    logic           fwd_a_o;
    logic           fwd_b_o;

    int n_chk  = 0;
    int n_fail = 0;

    logic [DW-1:0] rf_model [8];

    rf_write_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .N_REQ(NR)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .freeze_i     (freeze_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_addr_i   (req_addr_i),
        .req_data_i   (req_data_i),
        .rf_we_o      (rf_we_o),
        .rf_addr_wr_o (rf_addr_wr_o),
        .rf_data_o    (rf_data_o),
        .grant_id_o   (grant_id_o),
        .rd_addr_a_i  (rd_addr_a_i),
        .rd_addr_b_i  (rd_addr_b_i),
        .fwd_a_o      (fwd_a_o),
        .fwd_b_o      (fwd_b_o)
    );

    always #5 clk = ~clk;

    // Register-file image: captures whatever the write port commits at each edge.
    always @(posedge clk) begin
        if (rf_we_o) begin
            rf_model[rf_addr_wr_o] <= rf_data_o;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_addr_i[k*AW +: AW] = a;
        req_data_i[k*DW +: DW] = d;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) rf_model[i] = '0;
        rst_n       = 1'b0;
        freeze_i    = 1'b0;
        req_valid_i = '0;
        req_addr_i  = '0;
        req_data_i  = '0;
        rd_addr_a_i = '0;
        rd_addr_b_i = '0;
        for (int k = 0; k < NR; k++) set_req(k, AW'(k), DW'(32'hA0 + k));
        req_valid_i = 3'b111;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_we",    64'(rf_we_o), 64'd0);
        chk("reset_ready", 64'(req_ready_o), 64'd0);
        chk("reset_addr",  64'(rf_addr_wr_o), 64'd0);
        chk("reset_data",  64'(rf_data_o), 64'd0);
        chk("reset_gid",   64'(grant_id_o), 64'd0);

        // Round robin: all three valid continuously.
        rst_n = 1'b1;
        #1;
        chk("rr_first_ready", 64'(req_ready_o), 64'b001);
        for (int g = 0; g < 6; g++) begin
            tick();
            chk("rr_we",    64'(rf_we_o), 64'd1);
            chk("rr_gid",   64'(grant_id_o), 64'(g % 3));
            chk("rr_data",  64'(rf_data_o), 64'(32'hA0 + (g % 3)));
            chk("rr_ready", 64'(req_ready_o), 64'(3'b001 << ((g + 1) % 3)));
        end

        // Reset mid-stream with all valids still high.
        rst_n = 1'b0;
        #1;
        chk("midrst_we",    64'(rf_we_o), 64'd0);
        chk("midrst_ready", 64'(req_ready_o), 64'd0);
        chk("midrst_gid",   64'(grant_id_o), 64'd0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("postrst_ready", 64'(req_ready_o), 64'b001);
        tick();
        chk("postrst_we",  64'(rf_we_o), 64'd1);
        chk("postrst_gid", 64'(grant_id_o), 64'd0);
        req_valid_i = '0;
        tick();
        chk("idle_we",  64'(rf_we_o), 64'd0);
        chk("idle_gid", 64'(grant_id_o), 64'd0);

        // Single write from req1 (pointer is 1).
        set_req(1, 3'd5, 32'hDEADBEEF);
        req_valid_i = 3'b010;
        #1;
        chk("single_ready", 64'(req_ready_o), 64'b010);
        tick();
        req_valid_i = '0;
        #1;
        chk("single_we",    64'(rf_we_o), 64'd1);
        chk("single_addr",  64'(rf_addr_wr_o), 64'd5);
        chk("single_data",  64'(rf_data_o), 64'hDEADBEEF);
        chk("single_gid",   64'(grant_id_o), 64'd1);
        chk("single_ready_after", 64'(req_ready_o), 64'd0);
        tick();
        chk("single_we_off",   64'(rf_we_o), 64'd0);
        chk("single_addr_hold", 64'(rf_addr_wr_o), 64'd5);

        // Forwarding (pointer is 2).
        set_req(2, 3'd3, 32'h33);
        req_valid_i = 3'b100;
        #1;
        chk("fwd_ready", 64'(req_ready_o), 64'b100);
        tick();
        req_valid_i = '0;
        rd_addr_a_i = 3'd3;
        rd_addr_b_i = 3'd4;
        #1;
        chk("fwd_a_hit",  64'(fwd_a_o), 64'd1);
        chk("fwd_b_miss", 64'(fwd_b_o), 64'd0);
        rd_addr_b_i = 3'd3;
        #1;
        chk("fwd_b_hit",  64'(fwd_b_o), 64'd1);
        tick();
        chk("fwd_a_retired", 64'(fwd_a_o), 64'd0);
        rd_addr_a_i = '0;
        rd_addr_b_i = '0;

        // Freeze: move the pointer to 2, then stall for three edges.
        set_req(0, 3'd1, 32'h01);
        set_req(1, 3'd1, 32'h02);
        req_valid_i = 3'b011;
        #1;
        chk("frz_setup_r0", 64'(req_ready_o), 64'b001);
        tick();
        req_valid_i = 3'b010;
        #1;
        chk("frz_setup_r1", 64'(req_ready_o), 64'b010);
        tick();
        set_req(2, 3'd6, 32'h66);
        req_valid_i = 3'b101;
        freeze_i    = 1'b1;
        #1;
        chk("frz_ready_c1", 64'(req_ready_o), 64'd0);
        chk("frz_we_c1",    64'(rf_we_o), 64'd1);
        chk("frz_gid_c1",   64'(grant_id_o), 64'd1);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("frz_we",    64'(rf_we_o), 64'd0);
            chk("frz_ready", 64'(req_ready_o), 64'd0);
        end
        freeze_i = 1'b0;
        #1;
        chk("frz_release_ready", 64'(req_ready_o), 64'b100);
        tick();
        chk("frz_release_gid",  64'(grant_id_o), 64'd2);
        chk("frz_release_data", 64'(rf_data_o), 64'h66);
        req_valid_i = 3'b001;
        #1;
        chk("frz_next_ready", 64'(req_ready_o), 64'b001);
        tick();
        req_valid_i = '0;
        chk("frz_next_gid", 64'(grant_id_o), 64'd0);
        tick();

        // Collision on address 2 (pointer is 1).
        set_req(1, 3'd2, 32'h11);
        set_req(2, 3'd2, 32'h22);
        req_valid_i = 3'b110;
        #1;
        chk("col_ready1", 64'(req_ready_o), 64'b010);
        tick();
        req_valid_i = 3'b100;
        #1;
        chk("col_data1",  64'(rf_data_o), 64'h11);
        chk("col_gid1",   64'(grant_id_o), 64'd1);
        chk("col_ready2", 64'(req_ready_o), 64'b100);
        tick();
        req_valid_i = '0;
        #1;
        chk("col_data2", 64'(rf_data_o), 64'h22);
        chk("col_gid2",  64'(grant_id_o), 64'd2);
        tick();
        chk("col_rf2",  64'(rf_model[2]), 64'h22);
        chk("rf5_kept", 64'(rf_model[5]), 64'hDEADBEEF);
        chk("rf3_kept", 64'(rf_model[3]), 64'h33);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
